conv_rstl_pos_gen: RTL and testbench

//  Parametrised write-position generator for the convolution-result memory.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/conv_rstl_wrap_cnt.sv | 31 +++
 rtl/conv_rstl_pos_gen.sv | 174 +++++++++++++++++
 tb/tb_conv_rstl_pos_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: position-generator state encoding, width helper, default conv geometry.
package cnn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } pos_state_t;

   localparam int CONV_OUT_ROWS   = 26;
   localparam int CONV_OUT_COLS   = 26;
   localparam int CONV_RSTL_WORDS = CONV_OUT_ROWS * CONV_OUT_COLS;

   // Index buses never shrink below one bit, even for a single-entry dimension.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_rstl_wrap_cnt.sv
// Generic 0..MAX-1 counter: advances on inc, wrap flags the advance out of MAX-1, clr zeroes it.
module conv_rstl_wrap_cnt #(
   parameter int MAX = 2,
   parameter int W   = 1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] r_cnt;

   assign wrap = inc & (r_cnt == LAST);
   assign cnt  = r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= wrap ? '0 : r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/conv_rstl_pos_gen.sv
// Result-memory write-position generator: walks CHANNELS x OUT_ROWS x OUT_COLS, one position per en.
// Optional RSTL_POS_LAST_FLAGS_EN adds registered col_last/row_last/map_last outputs.
module conv_rstl_pos_gen
   import cnn_pkg::*;
#(
   parameter  int OUT_ROWS = CONV_OUT_ROWS,
   parameter  int OUT_COLS = CONV_OUT_COLS,
   parameter  int CHANNELS = 1,
   parameter  int ADDR_W   = 10,
   localparam int RW       = clog2_min1(OUT_ROWS),
   localparam int CW       = clog2_min1(OUT_COLS),
   localparam int HW       = clog2_min1(CHANNELS)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              clear,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic [RW-1:0]     row,
   output logic [CW-1:0]     col,
   output logic [HW-1:0]     ch,
   output logic              valid,
   output logic              busy,
`ifdef RSTL_POS_LAST_FLAGS_EN
   output logic              col_last,
   output logic              row_last,
   output logic              map_last,
`endif
   output logic              done
);

   pos_state_t        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;

   logic              w_adv;
   logic              w_col_wrap;
   logic              w_row_wrap;
   logic              w_ch_wrap;
   logic [CW-1:0]     w_col;
   logic [RW-1:0]     w_row;
   logic [HW-1:0]     w_ch;

   assign w_adv = (r_state == ST_RUN) & en & ~clear;

   conv_rstl_wrap_cnt #(.MAX(OUT_COLS), .W(CW)) u_col_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clear),
      .inc  (w_adv),
      .cnt  (w_col),
      .wrap (w_col_wrap)
   );

   conv_rstl_wrap_cnt #(.MAX(OUT_ROWS), .W(RW)) u_row_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clear),
      .inc  (w_col_wrap),
      .cnt  (w_row),
      .wrap (w_row_wrap)
   );

   // The channel wrap is exactly the consumption of the final position.
   conv_rstl_wrap_cnt #(.MAX(CHANNELS), .W(HW)) u_ch_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clear),
      .inc  (w_row_wrap),
      .cnt  (w_ch),
      .wrap (w_ch_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (clear) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= ST_RUN;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_adv) begin
                  if (w_ch_wrap) begin
                     r_state <= ST_DONE;
                     r_addr  <= '0;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_addr  <= r_addr + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_addr  <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RSTL_POS_LAST_FLAGS_EN
   localparam logic [CW-1:0] COL_MAX = CW'(OUT_COLS - 1);
   localparam logic [CW-1:0] COL_PRE = CW'((OUT_COLS > 1) ? OUT_COLS - 2 : 0);
   localparam logic [RW-1:0] ROW_MAX = RW'(OUT_ROWS - 1);
   localparam logic [RW-1:0] ROW_PRE = RW'((OUT_ROWS > 1) ? OUT_ROWS - 2 : 0);

   logic w_valid_nxt;
   logic w_col_last_nxt;
   logic w_row_last_nxt;
   logic r_col_last;
   logic r_row_last;
   logic r_map_last;

   // Flags are registered, so they are derived from where the counters land next cycle.
   assign w_valid_nxt    = ~clear & (((r_state == ST_IDLE) & start) |
                                     ((r_state == ST_RUN) & ~w_ch_wrap));
   assign w_col_last_nxt = w_adv ? ((OUT_COLS == 1) || (w_col == COL_PRE))
                                 : (w_col == COL_MAX);
   assign w_row_last_nxt = w_col_wrap ? ((OUT_ROWS == 1) || (w_row == ROW_PRE))
                                      : (w_row == ROW_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col_last <= 1'b0;
         r_row_last <= 1'b0;
         r_map_last <= 1'b0;
      end else begin
         r_col_last <= w_valid_nxt & w_col_last_nxt;
         r_row_last <= w_valid_nxt & w_row_last_nxt;
         r_map_last <= w_valid_nxt & w_col_last_nxt & w_row_last_nxt;
      end
   end

   assign col_last = r_col_last;
   assign row_last = r_row_last;
   assign map_last = r_map_last;
`endif

   assign addr  = r_addr;
   assign row   = w_row;
   assign col   = w_col;
   assign ch    = w_ch;
   assign valid = r_valid;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_conv_rstl_pos_gen.sv
// Directed bench for conv_rstl_pos_gen across default, 3x4x2, 1x1x1 and (optionally) 2x3 flag geometries.
module tb_conv_rstl_pos_gen;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // default 26x26x1
   logic d_start, d_clear, d_en;
   logic [9:0] d_addr;
   logic [4:0] d_row, d_col;
   logic [0:0] d_ch;
   logic d_valid, d_busy, d_done;

   // 3 rows x 4 cols x 2 channels
   logic b_start, b_clear, b_en;
   logic [4:0] b_addr;
   logic [1:0] b_row, b_col;
   logic [0:0] b_ch;
   logic b_valid, b_busy, b_done;

   // 1x1x1
   logic c_start, c_clear, c_en;
   logic [0:0] c_addr, c_row, c_col, c_ch;
   logic c_valid, c_busy, c_done;

`ifdef RSTL_POS_LAST_FLAGS_EN
   logic d_cl, d_rl, d_ml, b_cl, b_rl, b_ml, c_cl, c_rl, c_ml;
   logic f_start, f_clear, f_en;
   logic [2:0] f_addr;
   logic [0:0] f_row, f_ch;
   logic [1:0] f_col;
   logic f_valid, f_busy, f_done, f_cl, f_rl, f_ml;
`endif

   conv_rstl_pos_gen u_def (
      .clk(clk), .rst(rst), .start(d_start), .clear(d_clear), .en(d_en),
      .addr(d_addr), .row(d_row), .col(d_col), .ch(d_ch),
      .valid(d_valid), .busy(d_busy),
`ifdef RSTL_POS_LAST_FLAGS_EN
      .col_last(d_cl), .row_last(d_rl), .map_last(d_ml),
`endif
      .done(d_done)
   );

   conv_rstl_pos_gen #(.OUT_ROWS(3), .OUT_COLS(4), .CHANNELS(2), .ADDR_W(5)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .clear(b_clear), .en(b_en),
      .addr(b_addr), .row(b_row), .col(b_col), .ch(b_ch),
      .valid(b_valid), .busy(b_busy),
`ifdef RSTL_POS_LAST_FLAGS_EN
      .col_last(b_cl), .row_last(b_rl), .map_last(b_ml),
`endif
      .done(b_done)
   );

   conv_rstl_pos_gen #(.OUT_ROWS(1), .OUT_COLS(1), .CHANNELS(1), .ADDR_W(1)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .clear(c_clear), .en(c_en),
      .addr(c_addr), .row(c_row), .col(c_col), .ch(c_ch),
      .valid(c_valid), .busy(c_busy),
`ifdef RSTL_POS_LAST_FLAGS_EN
      .col_last(c_cl), .row_last(c_rl), .map_last(c_ml),
`endif
      .done(c_done)
   );

`ifdef RSTL_POS_LAST_FLAGS_EN
   conv_rstl_pos_gen #(.OUT_ROWS(2), .OUT_COLS(3), .CHANNELS(1), .ADDR_W(3)) u_f (
      .clk(clk), .rst(rst), .start(f_start), .clear(f_clear), .en(f_en),
      .addr(f_addr), .row(f_row), .col(f_col), .ch(f_ch),
      .valid(f_valid), .busy(f_busy),
      .col_last(f_cl), .row_last(f_rl), .map_last(f_ml),
      .done(f_done)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      d_start = 0; d_clear = 0; d_en = 0;
      b_start = 0; b_clear = 0; b_en = 0;
      c_start = 0; c_clear = 0; c_en = 0;
`ifdef RSTL_POS_LAST_FLAGS_EN
      f_start = 0; f_clear = 0; f_en = 0;
`endif
      #2;
      chk("rst_addr",  32'(d_addr),  0);
      chk("rst_valid", 32'(d_valid), 0);
      chk("rst_busy",  32'(d_busy),  0);
      chk("rst_done",  32'(d_done),  0);
      chk("rst_b_rowcol", 32'({b_row, b_col, b_ch}), 0);
      tick();
      rst = 1'b0;
      tick();

      // 1: default geometry, en held high
      d_start = 1; d_en = 1;
      tick();
      d_start = 0;
      chk("t1_first_addr",  32'(d_addr),  0);
      chk("t1_first_valid", 32'(d_valid), 1);
      chk("t1_first_busy",  32'(d_busy),  1);
      for (int k = 1; k <= 675; k++) begin
         tick();
         chk("t1_addr", 32'(d_addr), 32'(k));
         chk("t1_nodone", 32'(d_done), 0);
      end
      chk("t1_last_rowcol", 32'({d_row, d_col}), 32'({5'd25, 5'd25}));
      tick();
      chk("t1_done",       32'(d_done),  1);
      chk("t1_done_valid", 32'(d_valid), 0);
      chk("t1_done_addr",  32'(d_addr),  0);
      chk("t1_done_busy",  32'(d_busy),  1);
      tick();
      chk("t1_idle_done", 32'(d_done), 0);
      chk("t1_idle_busy", 32'(d_busy), 0);
      d_en = 0;

      // 2: 3x4x2 with en on alternate cycles
      b_start = 1;
      tick();
      b_start = 0;
      for (int i = 0; i < 24; i++) begin
         chk("t2_addr", 32'(b_addr), 32'(i));
         chk("t2_ch",   32'(b_ch),   32'(i / 12));
         chk("t2_row",  32'(b_row),  32'((i % 12) / 4));
         chk("t2_col",  32'(b_col),  32'(i % 4));
         if (i == 13) chk("t2_pos13", 32'({b_row, b_col, b_ch}), 32'({2'd0, 2'd1, 1'b1}));
         b_en = 0;
         tick();
         chk("t2_hold", 32'(b_addr), 32'(i));
         chk("t2_hold_valid", 32'(b_valid), 1);
         b_en = 1;
         tick();
      end
      b_en = 0;
      chk("t2_done",  32'(b_done),  1);
      chk("t2_valid", 32'(b_valid), 0);
      chk("t2_addr0", 32'(b_addr),  0);
      tick();
      chk("t2_idle", 32'({b_busy, b_done}), 0);

      // 3: clear at addr 100 with start in the same cycle
      d_start = 1; d_en = 1;
      tick();
      d_start = 0;
      repeat (100) tick();
      chk("t3_at100", 32'(d_addr), 100);
      d_clear = 1; d_start = 1;
      tick();
      d_clear = 0; d_start = 0;
      chk("t3_clr_addr",  32'(d_addr), 0);
      chk("t3_clr_state", 32'({d_valid, d_busy, d_done}), 0);
      chk("t3_clr_cnt",   32'({d_row, d_col}), 0);
      tick();
      chk("t3_idle_en", 32'({d_addr, d_valid, d_done}), 0);
      d_start = 1;
      tick();
      d_start = 0;
      chk("t3_restart", 32'({d_addr, d_valid}), 1);
      tick();
      chk("t3_restart_adv", 32'(d_addr), 1);
      repeat (49) tick();
      chk("t3_at50", 32'(d_addr), 50);

      // 4: async reset between edges
      #3 rst = 1'b1;
      #1;
      chk("t4_rst_addr", 32'(d_addr), 0);
      chk("t4_rst_ctl",  32'({d_valid, d_busy, d_done}), 0);
      chk("t4_rst_cnt",  32'({d_row, d_col, d_ch}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      tick();
      chk("t4_idle_addr", 32'(d_addr), 0);
      chk("t4_idle_ctl",  32'({d_valid, d_busy, d_done}), 0);
      d_en = 0;

      // 5: 1x1x1 with start held high throughout
      c_start = 1;
      tick();
      chk("t5_run", 32'({c_valid, c_busy, c_done}), 32'(3'b110));
      tick();
      chk("t5_hold", 32'({c_valid, c_busy, c_done}), 32'(3'b110));
      c_en = 1;
      tick();
      c_en = 0;
      chk("t5_done", 32'({c_valid, c_busy, c_done}), 32'(3'b011));
      tick();
      chk("t5_idle", 32'({c_valid, c_busy, c_done}), 0);
      tick();
      chk("t5_rerun", 32'({c_valid, c_busy, c_addr}), 32'(3'b110));
      c_start = 0;
      c_en = 1;
      tick();
      chk("t5_done2", 32'(c_done), 1);
      c_en = 0;
      tick();
      chk("t5_idle2", 32'({c_valid, c_busy, c_done}), 0);

`ifdef RSTL_POS_LAST_FLAGS_EN
      // 6: last flags on 2x3
      chk("t6_idle_flags", 32'({f_cl, f_rl, f_ml}), 0);
      f_start = 1; f_en = 1;
      tick();
      f_start = 0;
      for (int i = 0; i < 6; i++) begin
         chk("t6_addr",     32'(f_addr), 32'(i));
         chk("t6_col_last", 32'(f_cl), 32'((i % 3) == 2));
         chk("t6_row_last", 32'(f_rl), 32'((i / 3) == 1));
         chk("t6_map_last", 32'(f_ml), 32'(i == 5));
         tick();
      end
      f_en = 0;
      chk("t6_done",       32'(f_done), 1);
      chk("t6_done_flags", 32'({f_cl, f_rl, f_ml}), 0);
      tick();
      chk("t6_post_flags", 32'({f_cl, f_rl, f_ml}), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
